// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the three-port SDRAM arbiter.
// The optional round-robin mode for ports 1/2 is enabled by defining SDRAM_ARB_RR_EN.
package sdram_arb_pkg;

   localparam int unsigned NUM_PORTS = 3;
   localparam int unsigned ADDR_W    = 25;
   localparam int unsigned DATA_W    = 8;

   // Arbiter transaction FSM
   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_WAIT,
      GAP
   } state_t;

   // Index of a requesting port (0 = ROM loader, 1 = CPU, 2 = backup RAM)
   typedef logic [1:0] port_idx_t;

   localparam port_idx_t PORT_P0 = 2'd0;
   localparam port_idx_t PORT_P1 = 2'd1;
   localparam port_idx_t PORT_P2 = 2'd2;

endpackage

// File: rtl/sdram_arb_sel.sv
// Grant selector: picks one requesting port per cycle.
// p0 always wins; with SDRAM_ARB_RR_EN defined, p1/p2 ties alternate based on
// the last-served pointer, otherwise p1 always beats p2.
module sdram_arb_sel
   import sdram_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
`ifdef SDRAM_ARB_RR_EN
   input  port_idx_t            last,
`endif
   output port_idx_t            grant,
   output logic                 valid
);

   // Priority resolution, purely combinational
   always_comb begin
      grant = PORT_P0;
      valid = |req;
      if (req[0]) begin
         grant = PORT_P0;
`ifdef SDRAM_ARB_RR_EN
      end else if (req[1] && req[2]) begin
         grant = (last == PORT_P1) ? PORT_P2 : PORT_P1;
`endif
      end else if (req[1]) begin
         grant = PORT_P1;
      end else if (req[2]) begin
         grant = PORT_P2;
      end
   end

endmodule

// File: rtl/sdram_arb.sv
// Three-port SDRAM access arbiter: one transaction at a time, with an enforced
// idle gap after every access. Define SDRAM_ARB_RR_EN for p1/p2 round-robin.
module sdram_arb
   import sdram_arb_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 8
)
(
   input  logic              clk,
   input  logic              reset,

   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_din,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_dout,

   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_din,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_dout,

   input  logic              p2_req,
   input  logic              p2_we,
   input  logic [ADDR_W-1:0] p2_addr,
   input  logic [DATA_W-1:0] p2_din,
   output logic              p2_ack,
   output logic [DATA_W-1:0] p2_dout,

   output logic [ADDR_W-1:0] raddr,
   output logic              rd,
   input  logic              rd_rdy,
   output logic [ADDR_W-1:0] waddr,
   output logic [DATA_W-1:0] din,
   output logic              we,
   input  logic              we_ack,
   input  logic [DATA_W-1:0] dout
);

   localparam int unsigned      GCW      = $clog2(GAP_CYCLES) + 1;
   localparam logic [GCW-1:0]   GAP_LAST = GCW'(GAP_CYCLES - 1);

   state_t                 state, state_nx;
   port_idx_t              gnt;
   port_idx_t              sel_idx;
   logic                   sel_valid;
   logic [NUM_PORTS-1:0]   req_v;
   logic                   sel_we;
   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_din;
   logic [GCW-1:0]         gap_cnt;
   logic                   flush;
   logic                   grant_fire;
   logic                   rd_done;
   logic                   wr_done;
   logic [NUM_PORTS-1:0]   ack_r;
   logic [DATA_W-1:0]      dout_r [NUM_PORTS];

   assign req_v = {p2_req, p1_req, p0_req};

`ifdef SDRAM_ARB_RR_EN
   port_idx_t last;

   // Last-served pointer for the p1/p2 round-robin, advanced on completion
   always_ff @(posedge clk) begin
      if (reset) begin
         last <= PORT_P2;
      end else if ((rd_done || wr_done) && (gnt != PORT_P0)) begin
         last <= gnt;
      end
   end

   sdram_arb_sel u_sel (
      .req   (req_v),
      .last  (last),
      .grant (sel_idx),
      .valid (sel_valid)
   );
`else
   sdram_arb_sel u_sel (
      .req   (req_v),
      .grant (sel_idx),
      .valid (sel_valid)
   );
`endif

   // Route the winning requester's command fields to the latch inputs
   always_comb begin
      sel_we   = p0_we;
      sel_addr = p0_addr;
      sel_din  = p0_din;
      case (sel_idx)
         PORT_P1: begin
            sel_we   = p1_we;
            sel_addr = p1_addr;
            sel_din  = p1_din;
         end
         PORT_P2: begin
            sel_we   = p2_we;
            sel_addr = p2_addr;
            sel_din  = p2_din;
         end
         default: ;
      endcase
   end

   // FSM state register plus gap counter and post-reset flush flag
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         gap_cnt <= '0;
         flush   <= 1'b1;
      end else begin
         state <= state_nx;
         if (state == GAP && state_nx == GAP) begin
            gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end
         if (state == IDLE) begin
            flush <= 1'b0;
         end
      end
   end

   // Next-state decode and single-cycle transaction strobes
   // After reset the first IDLE visit is diverted through GAP so an abandoned
   // SDRAM access gets the full gap before anything new is granted.
   always_comb begin
      state_nx   = state;
      grant_fire = 1'b0;
      rd_done    = 1'b0;
      wr_done    = 1'b0;
      case (state)
         IDLE: begin
            if (flush) begin
               state_nx = GAP;
            end else if (sel_valid) begin
               grant_fire = 1'b1;
               state_nx   = sel_we ? WR_WAIT : RD_REQ;
            end
         end
         RD_REQ: begin
            if (!rd_rdy) begin
               state_nx = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (rd_rdy) begin
               rd_done  = 1'b1;
               state_nx = GAP;
            end
         end
         WR_WAIT: begin
            if (we_ack == we) begin
               wr_done  = 1'b1;
               state_nx = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // SDRAM-side command registers, held from grant until completion
   always_ff @(posedge clk) begin
      if (reset) begin
         gnt   <= PORT_P0;
         rd    <= 1'b0;
         raddr <= '0;
         waddr <= '0;
         din   <= '0;
         we    <= we_ack;
      end else begin
         if (grant_fire) begin
            gnt <= sel_idx;
            if (sel_we) begin
               waddr <= sel_addr;
               din   <= sel_din;
               we    <= ~we_ack;
            end else begin
               raddr <= sel_addr;
               rd    <= 1'b1;
            end
         end
         if (rd_done) begin
            rd <= 1'b0;
         end
      end
   end

   // Per-port ack pulses and read-data holding registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_r <= '0;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            dout_r[i] <= '0;
         end
      end else begin
         ack_r <= '0;
         for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (gnt == port_idx_t'(i)) begin
               if (rd_done) begin
                  dout_r[i] <= dout;
               end
               if (rd_done || wr_done) begin
                  ack_r[i] <= 1'b1;
               end
            end
         end
      end
   end

   assign p0_ack  = ack_r[0];
   assign p1_ack  = ack_r[1];
   assign p2_ack  = ack_r[2];
   assign p0_dout = dout_r[0];
   assign p1_dout = dout_r[1];
   assign p2_dout = dout_r[2];

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb with a small behavioural SDRAM controller model.
// Read data model: dout = raddr[7:0] ^ 8'hA4. Define SDRAM_ARB_RR_EN to match an RR build.
module tb_sdram_arb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0, p2_req = 0, p2_we = 0;
   logic [24:0] p0_addr = '0, p1_addr = '0, p2_addr = '0;
   logic [7:0]  p0_din = '0, p1_din = '0, p2_din = '0;
   logic        p0_ack, p1_ack, p2_ack;
   logic [7:0]  p0_dout, p1_dout, p2_dout;
   logic [24:0] raddr, waddr;
   logic        rd, we;
   logic [7:0]  din;
   logic        rd_rdy = 1'b1;
   logic        we_ack = 1'b0;
   logic [7:0]  dout = '0;

   int unsigned checks = 0;
   int unsigned errors = 0;

   sdram_arb #(.GAP_CYCLES(8)) dut (
      .clk(clk), .reset(reset),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_din(p0_din),
      .p0_ack(p0_ack), .p0_dout(p0_dout),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_din(p1_din),
      .p1_ack(p1_ack), .p1_dout(p1_dout),
      .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_din(p2_din),
      .p2_ack(p2_ack), .p2_dout(p2_dout),
      .raddr(raddr), .rd(rd), .rd_rdy(rd_rdy),
      .waddr(waddr), .din(din), .we(we), .we_ack(we_ack), .dout(dout)
   );

   always #5 clk = ~clk;

   // SDRAM controller model: read starts on rd rising edge, write on we != we_ack
   logic        rd_q = 1'b0;
   int unsigned rd_cnt = 0;
   int unsigned wr_cnt = 0;
   logic        wr_stall = 1'b0;
   int unsigned wr_count = 0;
   logic [24:0] wr_addr_log = '0;
   logic [7:0]  wr_data_log = '0;

   always @(posedge clk) begin
      rd_q <= rd;
      if (rd_cnt != 0) begin
         rd_cnt <= rd_cnt - 1;
         if (rd_cnt == 1) begin
            rd_rdy <= 1'b1;
            dout   <= raddr[7:0] ^ 8'hA4;
         end
      end else if (rd && !rd_q) begin
         rd_rdy <= 1'b0;
         rd_cnt <= 3;
      end
      if (we != we_ack && !wr_stall && !reset) begin
         if (wr_cnt == 2) begin
            we_ack      <= we;
            wr_addr_log <= waddr;
            wr_data_log <= din;
            wr_count    <= wr_count + 1;
            wr_cnt      <= 0;
         end else begin
            wr_cnt <= wr_cnt + 1;
         end
      end else begin
         wr_cnt <= 0;
      end
   end

   // Ack monitor: order log, per-port counts, overlap and pulse-width tracking
   int unsigned cyc = 0;
   int unsigned ack_total = 0;
   int unsigned ack_cnt [3] = '{0, 0, 0};
   int unsigned ack_log [$];
   int unsigned overlap = 0;
   int unsigned long_ack = 0;
   int unsigned rd_rise_cyc = 0;
   int unsigned last_ack_cyc = 0;
   logic [2:0]  prev_ack = '0;
   logic        rd_prev = 1'b0;
   logic [2:0]  ack_v;
   assign ack_v = {p2_ack, p1_ack, p0_ack};

   always @(negedge clk) begin
      cyc = cyc + 1;
      if ($countones(ack_v) > 1) overlap = overlap + 1;
      if ((ack_v & prev_ack) != 3'b000) long_ack = long_ack + 1;
      for (int i = 0; i < 3; i++) begin
         if (ack_v[i]) begin
            ack_cnt[i] = ack_cnt[i] + 1;
            ack_total  = ack_total + 1;
            ack_log.push_back(i);
            last_ack_cyc = cyc;
         end
      end
      if (rd && !rd_prev) rd_rise_cyc = cyc;
      prev_ack = ack_v;
      rd_prev  = rd;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(input int unsigned port, input int unsigned budget, output bit seen);
      int unsigned n = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         tick();
         n++;
         if (ack_v[port]) seen = 1'b1;
      end
   endtask

   task automatic run_acks(input int unsigned n, input bit drop, input int unsigned budget,
                           output bit ok);
      int unsigned start = ack_total;
      int unsigned k = 0;
      ok = 1'b0;
      while (!ok && k < budget) begin
         tick();
         k++;
         if (drop) begin
            if (p0_ack) p0_req = 1'b0;
            if (p1_ack) p1_req = 1'b0;
            if (p2_ack) p2_req = 1'b0;
         end
         if (ack_total >= start + n) ok = 1'b1;
      end
   endtask

   task automatic wait_we_toggle(input int unsigned budget, output bit seen);
      int unsigned n = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         tick();
         n++;
         if (we !== we_ack) seen = 1'b1;
      end
   endtask

   bit          ok;
   int unsigned rd_high;
   int unsigned acks_before, p2_before, wr_before, first_ack;
   int unsigned exp_seq [4];

   initial begin
      // Reset state
      repeat (3) tick();
      check("rst_rd", rd, 1'b0);
      check("rst_ack", ack_v, 3'b000);
      check("rst_p0_dout", p0_dout, 8'h00);
      check("rst_p1_dout", p1_dout, 8'h00);
      check("rst_p2_dout", p2_dout, 8'h00);
      check("rst_raddr", raddr, 25'h0);
      check("rst_waddr", waddr, 25'h0);
      check("rst_din", din, 8'h00);
      check("rst_we", we, 1'b0);
      reset = 1'b0;

      // Single CPU read
      p1_we = 1'b0; p1_addr = 25'h0000101; p1_req = 1'b1;
      wait_ack(1, 100, ok);
      check("rd1_ack_seen", ok, 1'b1);
      check("rd1_dout", p1_dout, 8'hA5);
      check("rd1_raddr", raddr, 25'h0000101);
      p1_req = 1'b0;
      tick();
      check("rd1_ack_pulse", p1_ack, 1'b0);
      rd_high = 0;
      repeat (8) begin
         if (rd) rd_high++;
         tick();
      end
      check("rd1_gap_rd_low", rd_high, 0);

      // Backup-RAM write at the top address
      p2_we = 1'b1; p2_addr = 25'h1FFFFFF; p2_din = 8'h3C; p2_req = 1'b1;
      wait_we_toggle(60, ok);
      check("wr1_we_toggle_seen", ok, 1'b1);
      check("wr1_we", we, 1'b1);
      check("wr1_waddr", waddr, 25'h1FFFFFF);
      check("wr1_din", din, 8'h3C);
      check("wr1_no_early_ack", p2_ack, 1'b0);
      wait_ack(2, 60, ok);
      check("wr1_ack_seen", ok, 1'b1);
      check("wr1_model_addr", wr_addr_log, 25'h1FFFFFF);
      check("wr1_model_data", wr_data_log, 8'h3C);
      check("wr1_p2_dout_kept", p2_dout, 8'h00);
      check("wr1_p1_dout_kept", p1_dout, 8'hA5);
      p2_req = 1'b0; p2_we = 1'b0;

      // Three-way contention, each requester drops on its own ack
      ack_log.delete();
      p0_we = 1'b0; p1_we = 1'b0; p2_we = 1'b0;
      p0_addr = 25'h10; p1_addr = 25'h20; p2_addr = 25'h30;
      p0_req = 1'b1; p1_req = 1'b1; p2_req = 1'b1;
      run_acks(3, 1'b1, 300, ok);
      check("cont_done", ok, 1'b1);
      check("cont_count", ack_log.size(), 3);
      if (ack_log.size() == 3) begin
         check("cont_order0", ack_log[0], 0);
         check("cont_order1", ack_log[1], 1);
         check("cont_order2", ack_log[2], 2);
      end
      check("cont_overlap", overlap, 0);
      check("cont_p0_dout", p0_dout, 8'hB4);
      check("cont_p1_dout", p1_dout, 8'h84);
      check("cont_p2_dout", p2_dout, 8'h94);

      // p1 and p2 held continuously
`ifdef SDRAM_ARB_RR_EN
      exp_seq = '{1, 2, 1, 2};
`else
      exp_seq = '{1, 1, 1, 1};
`endif
      ack_log.delete();
      p1_addr = 25'h40; p2_addr = 25'h50;
      p1_req = 1'b1; p2_req = 1'b1;
      run_acks(4, 1'b0, 400, ok);
      p1_req = 1'b0; p2_req = 1'b0;
      check("hold_done", ok, 1'b1);
      check("hold_count", ack_log.size(), 4);
      if (ack_log.size() == 4) begin
         for (int i = 0; i < 4; i++) check($sformatf("hold_grant%0d", i), ack_log[i], exp_seq[i]);
      end

      // ROM-loader write brings we back to 0
      p0_we = 1'b1; p0_addr = 25'h0000200; p0_din = 8'h77; p0_req = 1'b1;
      wait_ack(0, 100, ok);
      p0_req = 1'b0; p0_we = 1'b0;
      check("wr2_ack_seen", ok, 1'b1);
      check("wr2_model_addr", wr_addr_log, 25'h0000200);
      check("wr2_model_data", wr_data_log, 8'h77);
      check("wr2_p0_dout_kept", p0_dout, 8'hB4);
      check("wr2_we_ack", we_ack, 1'b0);

      // Reset while stuck in WR_WAIT
      wr_stall = 1'b1;
      acks_before = ack_total;
      p2_before = ack_cnt[2];
      p2_we = 1'b1; p2_addr = 25'h0000123; p2_din = 8'h5A; p2_req = 1'b1;
      wait_we_toggle(60, ok);
      check("wrst_we_toggle_seen", ok, 1'b1);
      check("wrst_we", we, 1'b1);
      check("wrst_we_ack", we_ack, 1'b0);
      repeat (3) tick();
      wr_before = wr_count;
      reset = 1'b1;
      p2_req = 1'b0; p2_we = 1'b0;
      repeat (2) tick();
      check("wrst_we_eq_ack", we, we_ack);
      check("wrst_p0_dout_clr", p0_dout, 8'h00);
      reset = 1'b0;
      wr_stall = 1'b0;
      repeat (12) tick();
      check("wrst_no_ack", ack_total, acks_before);
      check("wrst_no_write", wr_count, wr_before);
      p1_we = 1'b0; p1_addr = 25'h00000AB; p1_req = 1'b1;
      wait_ack(1, 100, ok);
      p1_req = 1'b0;
      check("wrst_next_ack_seen", ok, 1'b1);
      check("wrst_next_dout", p1_dout, 8'h0F);
      check("wrst_p2_no_ack", ack_cnt[2], p2_before);

      // Back-to-back p1 reads, req held through the first ack
      p1_addr = 25'h00000C1; p1_req = 1'b1;
      wait_ack(1, 100, ok);
      check("b2b_ack1_seen", ok, 1'b1);
      check("b2b_dout1", p1_dout, 8'h65);
      first_ack = last_ack_cyc;
      p1_addr = 25'h00000D2;
      wait_ack(1, 100, ok);
      p1_req = 1'b0;
      check("b2b_ack2_seen", ok, 1'b1);
      check("b2b_dout2", p1_dout, 8'h76);
      // 8 GAP clocks plus the IDLE grant clock separate ack from next rd rise
      check("b2b_rd_spacing", rd_rise_cyc - first_ack, 9);

      repeat (4) tick();
      check("ack_single_pulse", long_ack, 0);
      check("ack_no_overlap", overlap, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
